lbp_engine: RTL and testbench

LBP_ENGINE -- requirements
Module: lbp_engine

---
 rtl/lbp_pkg.sv | 28 ++
 rtl/lbp_if.sv | 31 +++
 rtl/lbp_cmp.sv | 27 ++
 rtl/lbp_engine.sv | 186 ++++++++++++++++++
 tb/tb_lbp_engine.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lbp_pkg.sv
// Shared constants for the LBP engine family: FSM encodings, code bit positions,
// window slot layout and per-column read counts.
package lbp_pkg;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_CALC  = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // Bit positions of each neighbour inside the 8-bit code.
   localparam int BIT_TL = 0;
   localparam int BIT_T  = 1;
   localparam int BIT_TR = 2;
   localparam int BIT_L  = 3;
   localparam int BIT_R  = 4;
   localparam int BIT_BL = 5;
   localparam int BIT_B  = 6;
   localparam int BIT_BR = 7;

   // Window slots are row_offset*3 + col_offset, row 0 on top.
   localparam int SLOT_C = 4;

   localparam logic [3:0] FILL_READS  = 4'd9;
   localparam logic [3:0] SHIFT_READS = 4'd3;

endpackage

// File: rtl/lbp_if.sv
// Engine-side bundle: gray read port, LBP write port and frame control/status.
// Handshakes: a gray read returns data exactly one cycle after gray_req; an LBP
// write transfers on a cycle where lbp_valid and lbp_ready are both high, and
// the master holds lbp_valid/addr/data stable until that cycle.
interface lbp_if #(
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 14
);
   logic              gray_ready;
   logic              gray_req;
   logic [ADDR_W-1:0] gray_addr;
   logic [PIX_W-1:0]  gray_data;
   logic [PIX_W-1:0]  thr;
   logic              border_zero;
   logic              lbp_valid;
   logic [ADDR_W-1:0] lbp_addr;
   logic [7:0]        lbp_data;
   logic              lbp_ready;
   logic              busy;
   logic              finish;

   modport master (
      input  gray_ready, gray_data, thr, border_zero, lbp_ready,
      output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, busy, finish
   );

   modport slave (
      output gray_ready, gray_data, thr, border_zero, lbp_ready,
      input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, busy, finish
   );
endinterface

// File: rtl/lbp_cmp.sv
// Combinational LBP code: each neighbour contributes 1 when it is at least
// centre+thr, the sum kept one bit wider so it never wraps.
module lbp_cmp
   import lbp_pkg::*;
#(
   parameter int PIX_W = 8
)(
   input  logic [8:0][PIX_W-1:0] i_win,
   input  logic [PIX_W-1:0]      i_thr,
   output logic [7:0]            o_code
);
   logic [PIX_W:0] w_ref;

   assign w_ref = {1'b0, i_win[SLOT_C]} + {1'b0, i_thr};

   always_comb begin
      o_code         = '0;
      o_code[BIT_TL] = ({1'b0, i_win[0]} >= w_ref);
      o_code[BIT_T]  = ({1'b0, i_win[1]} >= w_ref);
      o_code[BIT_TR] = ({1'b0, i_win[2]} >= w_ref);
      o_code[BIT_L]  = ({1'b0, i_win[3]} >= w_ref);
      o_code[BIT_R]  = ({1'b0, i_win[5]} >= w_ref);
      o_code[BIT_BL] = ({1'b0, i_win[6]} >= w_ref);
      o_code[BIT_B]  = ({1'b0, i_win[7]} >= w_ref);
      o_code[BIT_BR] = ({1'b0, i_win[8]} >= w_ref);
   end
endmodule

// File: rtl/lbp_engine.sv
// Raster-order LBP engine: reads a 3x3 window per interior pixel (full fill at
// the row start, one new column afterwards) and writes one code per pixel.
module lbp_engine
   import lbp_pkg::*;
#(
   parameter int IMG_W  = 128,
   parameter int IMG_H  = 128,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 14
)(
   input  logic   clk,
   input  logic   rst,
   lbp_if.master  bus,
   output logic [2:0] o_state
);
   localparam logic [ADDR_W-1:0] C_W          = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] C_ONE        = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] C_LAST_COL   = ADDR_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] C_LAST_ROW   = ADDR_W'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] C_LAST_ICOL  = ADDR_W'(IMG_W - 2);
   localparam logic [ADDR_W-1:0] C_LAST_IROW  = ADDR_W'(IMG_H - 2);

   logic [2:0]              r_state;
   logic [ADDR_W-1:0]       r_row, r_col;
   logic [3:0]              r_cnt;
   logic [1:0]              r_roff, r_coff;
   logic                    r_cap_v;
   logic [3:0]              r_cap_slot;
   logic [8:0][PIX_W-1:0]   r_win;
   logic [PIX_W-1:0]        r_thr;
   logic                    r_bz;
   logic                    r_lbp_valid;
   logic [ADDR_W-1:0]       r_lbp_addr;
   logic [7:0]              r_lbp_data;

   logic                    w_reading, w_last_rd, w_accept, w_enter;
   logic [ADDR_W-1:0]       w_rd_row, w_rd_col;
   logic [3:0]              w_slot;
   logic [ADDR_W-1:0]       w_nx_row, w_nx_col, w_nx_addr;
   logic                    w_nx_end, w_nx_border;
   logic [8:0][PIX_W-1:0]   w_win;
   logic [7:0]              w_code;

   assign w_reading = (r_state == S_FILL) || (r_state == S_SHIFT);
   assign w_last_rd = ((r_state == S_FILL)  && (r_cnt == FILL_READS - 4'd1)) ||
                      ((r_state == S_SHIFT) && (r_cnt == SHIFT_READS - 4'd1));
   assign w_accept  = (r_state == S_OUT) && bus.lbp_ready;
   assign w_rd_row  = r_row + {{(ADDR_W-2){1'b0}}, r_roff} - C_ONE;
   assign w_rd_col  = r_col + {{(ADDR_W-2){1'b0}}, r_coff} - C_ONE;
   assign w_slot    = ({2'b00, r_roff} * 4'd3) + {2'b00, r_coff};

   // Position of the next pixel to emit; from IDLE it is the frame's first one.
   always_comb begin
      w_nx_row = r_row;
      w_nx_col = r_col + C_ONE;
      w_nx_end = 1'b0;
      if (r_bz) begin
         if (r_col == C_LAST_COL) begin
            w_nx_col = '0;
            w_nx_row = r_row + C_ONE;
            w_nx_end = (r_row == C_LAST_ROW);
         end
      end else if (r_col == C_LAST_ICOL) begin
         w_nx_col = C_ONE;
         w_nx_row = r_row + C_ONE;
         w_nx_end = (r_row == C_LAST_IROW);
      end
      if (r_state == S_IDLE) begin
         w_nx_end = 1'b0;
         w_nx_row = bus.border_zero ? '0 : C_ONE;
         w_nx_col = bus.border_zero ? '0 : C_ONE;
      end
   end

   assign w_nx_border = (w_nx_row == '0) || (w_nx_row == C_LAST_ROW) ||
                        (w_nx_col == '0) || (w_nx_col == C_LAST_COL);
   assign w_nx_addr   = w_nx_row * C_W + w_nx_col;
   assign w_enter     = ((r_state == S_IDLE) && bus.gray_ready) || (w_accept && !w_nx_end);

   // The comparator sees the pixel arriving this cycle so CALC needs no extra wait.
   always_comb begin
      w_win = r_win;
      if (r_cap_v) w_win[r_cap_slot] = bus.gray_data;
   end

   lbp_cmp #(.PIX_W(PIX_W)) u_cmp (
      .i_win  (w_win),
      .i_thr  (r_thr),
      .o_code (w_code)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_row       <= '0;
         r_col       <= '0;
         r_cnt       <= '0;
         r_roff      <= '0;
         r_coff      <= '0;
         r_cap_v     <= 1'b0;
         r_cap_slot  <= '0;
         r_win       <= '0;
         r_thr       <= '0;
         r_bz        <= 1'b0;
         r_lbp_valid <= 1'b0;
         r_lbp_addr  <= '0;
         r_lbp_data  <= '0;
      end else begin
         r_cap_v    <= w_reading;
         r_cap_slot <= w_slot;
         if (r_cap_v) r_win[r_cap_slot] <= bus.gray_data;

         if ((r_state == S_IDLE) && bus.gray_ready) begin
            r_thr <= bus.thr;
            r_bz  <= bus.border_zero;
         end

         if (w_enter) begin
            r_row  <= w_nx_row;
            r_col  <= w_nx_col;
            r_cnt  <= '0;
            r_roff <= '0;
            if (w_nx_border) begin
               r_state     <= S_OUT;
               r_lbp_valid <= 1'b1;
               r_lbp_addr  <= w_nx_addr;
               r_lbp_data  <= '0;
            end else if (w_nx_col == C_ONE) begin
               r_state     <= S_FILL;
               r_lbp_valid <= 1'b0;
               r_coff      <= 2'd0;
            end else begin
               r_state     <= S_SHIFT;
               r_lbp_valid <= 1'b0;
               r_coff      <= 2'd2;
               for (int i = 0; i < 3; i++) begin
                  r_win[i*3]   <= r_win[i*3+1];
                  r_win[i*3+1] <= r_win[i*3+2];
               end
            end
         end else begin
            case (r_state)
               S_FILL, S_SHIFT: begin
                  if (w_last_rd) begin
                     r_state <= S_CALC;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                     if (r_roff == 2'd2) begin
                        r_roff <= 2'd0;
                        r_coff <= r_coff + 2'd1;
                     end else begin
                        r_roff <= r_roff + 2'd1;
                     end
                  end
               end
               S_CALC: begin
                  r_state     <= S_OUT;
                  r_lbp_valid <= 1'b1;
                  r_lbp_addr  <= r_row * C_W + r_col;
                  r_lbp_data  <= w_code;
               end
               S_OUT: begin
                  if (w_accept) begin
                     r_lbp_valid <= 1'b0;
                     r_state     <= S_DONE;
                  end
               end
               S_DONE: begin
                  if (!bus.gray_ready) r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.gray_req  = w_reading;
   assign bus.gray_addr = w_reading ? (w_rd_row * C_W + w_rd_col) : '0;
   assign bus.lbp_valid = r_lbp_valid;
   assign bus.lbp_addr  = r_lbp_addr;
   assign bus.lbp_data  = r_lbp_data;
   assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
   assign bus.finish    = (r_state == S_DONE);
   assign o_state       = r_state;

endmodule

// File: tb/tb_lbp_engine.sv
// Bench for lbp_engine: a 4x4 and a 3x3 instance, a shared pixel memory and a
// frame-level reference model that scores every write and the read count.
module tb_lbp_engine;
  localparam int AW = 8;
  localparam int PW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lbp_if #(.PIX_W(PW), .ADDR_W(AW)) b4 ();
  lbp_if #(.PIX_W(PW), .ADDR_W(AW)) b3 ();
  logic [2:0] st4, st3;

  lbp_engine #(.IMG_W(4), .IMG_H(4), .PIX_W(PW), .ADDR_W(AW)) u4 (
    .clk(clk), .rst(rst), .bus(b4), .o_state(st4));
  lbp_engine #(.IMG_W(3), .IMG_H(3), .PIX_W(PW), .ADDR_W(AW)) u3 (
    .clk(clk), .rst(rst), .bus(b3), .o_state(st3));

  int n_err = 0;
  int n_chk = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int exp_reads;
  int rd_cnt = 0;
  int dsel = 4;
  int mode = 0;
  logic go = 1'b0;
  logic t_ready = 1'b1;
  logic t_bz = 1'b0;
  logic [7:0] t_thr = 8'h00;
  logic [7:0] mem [16];

  assign b4.gray_ready  = go && (dsel == 4);
  assign b3.gray_ready  = go && (dsel == 3);
  assign b4.thr         = t_thr;
  assign b3.thr         = t_thr;
  assign b4.border_zero = t_bz;
  assign b3.border_zero = t_bz;
  assign b4.lbp_ready   = t_ready;
  assign b3.lbp_ready   = t_ready;

  // pixel memory: data one cycle after the request
  always @(posedge clk) begin
    b4.gray_data <= mem[b4.gray_addr[3:0]];
    b3.gray_data <= mem[b3.gray_addr[3:0]];
  end

  // sink ready: 0 = always ready, 1 = random, 2 = left to the stimulus
  always @(posedge clk) begin
    #1;
    if (mode == 1) t_ready = ($urandom_range(0, 3) != 0);
    else if (mode == 0) t_ready = 1'b1;
  end

  logic m_valid, m_req, m_busy, m_finish;
  logic [AW-1:0] m_addr;
  logic [7:0] m_data;
  assign m_valid  = (dsel == 4) ? b4.lbp_valid : b3.lbp_valid;
  assign m_req    = (dsel == 4) ? b4.gray_req  : b3.gray_req;
  assign m_busy   = (dsel == 4) ? b4.busy      : b3.busy;
  assign m_finish = (dsel == 4) ? b4.finish    : b3.finish;
  assign m_addr   = (dsel == 4) ? b4.lbp_addr  : b3.lbp_addr;
  assign m_data   = (dsel == 4) ? b4.lbp_data  : b3.lbp_data;

  // writes accepted at the next edge, reads issued this cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && t_ready) got_q.push_back({m_addr, m_data});
      if (m_req) rd_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: every pixel in raster order, neighbour >= centre+thr in plain ints
  task automatic build_exp(input int w, input int thr, input bit bz);
    int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int code;
    exp_q.delete();
    exp_reads = (w - 2) * (9 + 3 * (w - 3));
    for (int r = 0; r < w; r++) begin
      for (int c = 0; c < w; c++) begin
        if (r == 0 || c == 0 || r == w - 1 || c == w - 1) begin
          if (bz) exp_q.push_back({8'(r * w + c), 8'h00});
        end else begin
          code = 0;
          for (int b = 0; b < 8; b++)
            if (int'(mem[(r + dr[b]) * w + c + dc[b]]) >= int'(mem[r * w + c]) + thr)
              code = code | (1 << b);
          exp_q.push_back({8'(r * w + c), 8'(code)});
        end
      end
    end
  endtask

  task automatic start_frame(input int w, input logic [7:0] thr, input bit bz, input bit scr);
    dsel = w;
    t_thr = thr;
    t_bz = bz;
    build_exp(w, int'(thr), bz);
    got_q.delete();
    rd_cnt = 0;
    @(posedge clk);
    #1 go = 1'b1;
    repeat (2) @(negedge clk);
    check_val("busy_start", 32'(m_busy), 32'd1);
    if (scr) begin
      t_thr = 8'($urandom);
      t_bz = 1'($urandom);
    end
  endtask

  task automatic end_frame();
    int k = 0;
    while (!m_finish && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check_val("finish", 32'(m_finish), 32'd1);
    check_val("busy_done", 32'(m_busy), 32'd0);
    check_val("n_writes", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got_q.size()) check_val("write", 32'(got_q[i]), 32'(exp_q[i]));
    check_val("reads", 32'(rd_cnt), 32'(exp_reads));
    repeat (3) @(negedge clk);
    check_val("finish_hold", 32'(m_finish), 32'd1);
    go = 1'b0;
    repeat (2) @(negedge clk);
    check_val("finish_clear", 32'(m_finish), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] s_addr;
    logic [7:0] s_data;
    int k;
    int w;

    // reset state
    #12;
    check_val("rst_req", 32'(b4.gray_req), 32'd0);
    check_val("rst_gaddr", 32'(b4.gray_addr), 32'd0);
    check_val("rst_valid", 32'(b4.lbp_valid), 32'd0);
    check_val("rst_laddr", 32'(b4.lbp_addr), 32'd0);
    check_val("rst_ldata", 32'(b4.lbp_data), 32'd0);
    check_val("rst_busy", 32'(b4.busy), 32'd0);
    check_val("rst_finish", 32'(b4.finish), 32'd0);
    check_val("rst_state", 32'(st4), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // flat 4x4 frame: four interior codes of all ones
    for (int i = 0; i < 16; i++) mem[i] = 8'h40;
    start_frame(4, 8'h00, 1'b0, 1'b0);
    end_frame();
    check_val("flat_data", 32'((got_q.size() > 0) ? got_q[0][7:0] : 8'h00), 32'hFF);

    // 3x3 ramp around a 0x50 centre
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40;
    mem[4] = 8'h50; mem[5] = 8'h50; mem[6] = 8'h60; mem[7] = 8'h70; mem[8] = 8'h80;
    start_frame(3, 8'h00, 1'b0, 1'b0);
    end_frame();
    check_val("ramp_thr0", 32'((got_q.size() > 0) ? got_q[0] : 16'h0), 32'h04F0);
    start_frame(3, 8'h30, 1'b0, 1'b0);
    end_frame();
    start_frame(3, 8'hFF, 1'b0, 1'b0);
    end_frame();
    check_val("ramp_thrff", 32'((got_q.size() > 0) ? got_q[0] : 16'h0), 32'h0400);

    // 4x4 with border writes
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
    start_frame(4, 8'h08, 1'b1, 1'b1);
    end_frame();

    // sink stall during OUT
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
    mode = 2;
    t_ready = 1'b0;
    start_frame(4, 8'h10, 1'b0, 1'b0);
    k = 0;
    while (!m_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val("stall_valid", 32'(m_valid), 32'd1);
    s_addr = m_addr;
    s_data = m_data;
    repeat (5) begin
      @(negedge clk);
      check_val("stall_hold_v", 32'(m_valid), 32'd1);
      check_val("stall_hold_a", 32'(m_addr), 32'(s_addr));
      check_val("stall_hold_d", 32'(m_data), 32'(s_data));
      check_val("stall_no_req", 32'(m_req), 32'd0);
    end
    mode = 0;
    end_frame();

    // randomized frames
    for (int it = 0; it < 8; it++) begin
      w = $urandom_range(3, 4);
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 1);
      start_frame(w, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255))
                                                 : 8'($urandom_range(0, 40)),
                  1'($urandom), 1'b1);
      end_frame();
      mode = 0;
    end

    // reset in the middle of the second interior row pixel, then a clean rerun
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
    start_frame(4, 8'h04, 1'b0, 1'b0);
    k = 0;
    while (got_q.size() < 1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_val("pre_rst_write", 32'(got_q.size()), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("abort_req", 32'(b4.gray_req), 32'd0);
    check_val("abort_gaddr", 32'(b4.gray_addr), 32'd0);
    check_val("abort_valid", 32'(b4.lbp_valid), 32'd0);
    check_val("abort_ldata", 32'(b4.lbp_data), 32'd0);
    check_val("abort_busy", 32'(b4.busy), 32'd0);
    check_val("abort_state", 32'(st4), 32'd0);
    got_q.delete();
    rd_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    end_frame();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
